// File: rtl/rr_svi_arbiter.sv
// rr_svi_arbiter
//   Round-robin arbiter with a guaranteed one-cycle bubble between grants
//   and a bounded grant-hold time.
//
//   Flow: IDLE samples i_req and registers a winner -> GRANT holds a stable
//   one-hot grant until the owner releases, drops its request or the hold
//   counter reaches TIMEOUT -> REST (one cycle, no grant) -> IDLE.
//
// Ports
//   i_clk      : clock, all state updates on the rising edge
//   i_arst_n   : asynchronous active-low reset
//   i_req      : per-channel level request
//   i_release  : per-channel one-cycle release strobe (only the owner's bit matters)
//   o_gnt      : one-hot (or zero) grant
//   o_gnt_id   : index of the granted channel, 0 when nothing is granted
//   o_busy     : high whenever the arbiter is not IDLE
//   o_timeout  : one-cycle pulse, in the first REST cycle, when a grant was
//                revoked by the hold counter
module rr_svi_arbiter #(
    parameter int N_REQ   = 8,
    parameter int TIMEOUT = 15,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic [N_REQ-1:0]  i_req,
    input  logic [N_REQ-1:0]  i_release,
    output logic [N_REQ-1:0]  o_gnt,
    output logic [ID_W-1:0]   o_gnt_id,
    output logic              o_busy,
    output logic              o_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_REST  = 2'd2
    } state_t;

    localparam logic [7:0]      TIMEOUT_L = 8'(TIMEOUT);
    localparam logic [ID_W-1:0] PTR_INIT  = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]   N_REQ_W   = (ID_W + 1)'(N_REQ);

    state_t          state_reg, state_next;
    logic [ID_W-1:0] owner_reg, owner_next;
    logic [ID_W-1:0] ptr_reg, ptr_next;
    logic [7:0]      hold_reg, hold_next;
    logic            timeout_reg, timeout_next;

    // Round-robin search: first requester scanning upward from ptr+1.
    // The sum is one bit wider than an index so ptr+k (at most 2*N_REQ-1)
    // never overflows before the modulo correction.
    logic            win_found;
    logic [ID_W-1:0] win_idx;
    logic [ID_W:0]   scan_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = {1'b0, ptr_reg} + (ID_W + 1)'(k);
            if (scan_idx >= N_REQ_W) begin
                scan_idx = scan_idx - N_REQ_W;
            end
            if (!win_found && i_req[scan_idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= '0;
            ptr_reg     <= PTR_INIT;
            hold_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
            hold_reg    <= hold_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        hold_next    = hold_reg;
        timeout_next = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    state_next = ST_GRANT;
                    owner_next = win_idx;
                    hold_next  = '0;
                end
            end
            ST_GRANT: begin
                // Release / request drop outrank the timeout so a voluntary
                // hand-back in the last allowed cycle is never flagged.
                if (i_release[owner_reg] || !i_req[owner_reg]) begin
                    state_next = ST_REST;
                    ptr_next   = owner_reg;
                end else if (hold_reg == TIMEOUT_L) begin
                    state_next   = ST_REST;
                    ptr_next     = owner_reg;
                    timeout_next = 1'b1;
                end else if (hold_reg != 8'hFF) begin
                    hold_next = hold_reg + 8'd1;
                end
            end
            ST_REST: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state so reset removes the grant
    // immediately, without waiting for a clock edge.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
            assign o_gnt[gi] = (state_reg == ST_GRANT) && (owner_reg == ID_W'(gi));
        end
    endgenerate

    assign o_gnt_id  = (state_reg == ST_GRANT) ? owner_reg : '0;
    assign o_busy    = (state_reg != ST_IDLE);
    assign o_timeout = timeout_reg;

endmodule
